// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive-side framer.
// Holds the framer state encoding, the err_code values reported with
// frame_err, the default sync byte and a saturating-increment helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } framerState_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Increment an 8-bit count, sticking at 255 instead of wrapping.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// uart_timeout_ctr: inter-byte timeout down-counter for the framer.
// Loaded on every reload; while enabled it counts down toward zero.
// expired is raised in the cycle that completes TIMEOUT_CYCLES-1 silent
// cycles after the last reload, unless a reload arrives in that same cycle.
module uart_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);

  // The value after a reload already accounts for the first silent cycle,
  // so the count reaches zero on the (TIMEOUT_CYCLES-1)th silent cycle.
  localparam logic [W-1:0] RELOAD_VAL = W'(TIMEOUT_CYCLES - 2);

  logic [W-1:0] r_count;

  // Reload on any accepted byte, otherwise count down while the frame is open.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= RELOAD_VAL;
    end else if (reload) begin
      r_count <= RELOAD_VAL;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = enable && !reload && (r_count == '0);

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: hunts for a sync byte in the uart_rx byte stream,
// validates a length-prefixed, checksummed frame and streams the payload
// with first/last markers. Every frame that leaves HUNT ends with exactly
// one frame_ok or frame_err pulse.
// Build option: define UART_FRAMER_TIMEOUT_EN to include the inter-byte
// timeout (err_code 11); without it frames wait indefinitely for bytes.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       pl_first,
  output logic       pl_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  framerState_t r_state;
  logic [7:0]   r_remaining;
  logic [7:0]   r_acc;
  logic         r_first;
  logic         w_expired;

`ifdef UART_FRAMER_TIMEOUT_EN
  logic w_ctrEnable;

  assign w_ctrEnable = (r_state != ST_HUNT);

  uart_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeoutCtr (
    .clk    (clk),
    .reset  (reset),
    .reload (in_valid),
    .enable (w_ctrEnable),
    .expired(w_expired)
  );
`else
  logic w_unusedTimeoutCfg;

  assign w_expired          = 1'b0;
  assign w_unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
`endif

  // Framer state machine; all strobes are registered one cycle after the byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_HUNT;
      r_remaining <= 8'd0;
      r_acc       <= 8'd0;
      r_first     <= 1'b0;
      pl_data     <= 8'd0;
      pl_valid    <= 1'b0;
      pl_first    <= 1'b0;
      pl_last     <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
      drop_cnt    <= 8'd0;
    end else begin
      pl_valid  <= 1'b0;
      pl_first  <= 1'b0;
      pl_last   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if ((r_state != ST_HUNT) && w_expired) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        r_state   <= ST_HUNT;
      end else if (in_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (in_data == SYNC_BYTE) begin
              r_acc   <= 8'd0;
              r_state <= ST_LEN;
            end else begin
              drop_cnt <= satInc8(drop_cnt);
            end
          end
          ST_LEN: begin
            if ((in_data == 8'd0) || (in_data > MAX_LEN_B)) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              r_state   <= ST_HUNT;
            end else begin
              r_remaining <= in_data;
              r_acc       <= in_data;
              r_first     <= 1'b1;
              r_state     <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            pl_data     <= in_data;
            pl_valid    <= 1'b1;
            pl_first    <= r_first;
            pl_last     <= (r_remaining == 8'd1);
            r_first     <= 1'b0;
            r_acc       <= r_acc + in_data;
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              r_state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (in_data == r_acc) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
            r_state <= ST_HUNT;
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: scoreboard bench for uart_rx_framer.
// Frames are issued at frame level; the expected strobes (payload bytes,
// frame_ok, frame_err with cause) and the cycle they must appear in are
// queued, and a negedge monitor pops and compares them as the DUT emits.
module tb_uart_rx_framer;
  import uart_pkg::*;

  localparam int         MaxLen        = 16;
  localparam int         TimeoutCycles = 100;
  localparam logic [7:0] SyncByte      = 8'hA5;

  localparam logic [1:0] KindPl  = 2'd0;
  localparam logic [1:0] KindOk  = 2'd1;
  localparam logic [1:0] KindErr = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic        first;
    logic        last;
    logic [1:0]  code;
    logic [31:0] cyc;
  } expEvent_t;

  typedef logic [7:0] byteQ_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_first;
  logic       pl_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  int        checks = 0;
  int        errors = 0;
  int        cycleCount = 0;
  int        dropModel = 0;
  expEvent_t expQ[$];
  expEvent_t monEvent;
  logic [1:0] monKind;

  uart_rx_framer #(
    .SYNC_BYTE     (SyncByte),
    .MAX_LEN       (MaxLen),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_first (pl_first),
    .pl_last  (pl_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .drop_cnt (drop_cnt)
  );

  // Free-running clock and a cycle counter used to time expected strobes.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cycleCount);
    end
  endtask

  task automatic pushEvent(input logic [1:0] kind, input logic [7:0] data, input logic first,
                           input logic last, input logic [1:0] code, input int cyc);
    expEvent_t e;
    e.kind  = kind;
    e.data  = data;
    e.first = first;
    e.last  = last;
    e.code  = code;
    e.cyc   = cyc;
    expQ.push_back(e);
  endtask

  // Drive one byte strobe; cyc is the cycle its registered response shows up in.
  task automatic sendByte(input logic [7:0] b, output int cyc);
    cyc      = cycleCount + 1;
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendNoise(input logic [7:0] b);
    int c;
    sendByte(b, c);
    if (dropModel < 255) dropModel++;
  endtask

  // One complete frame attempt: sync, length, payload and checksum.
  task automatic applyStimulus(input logic [7:0] len, input byteQ_t payload,
                               input logic [7:0] chk, input int maxGap);
    int         c;
    logic [7:0] sum;
    sendByte(SyncByte, c);
    idle(int'($urandom_range(0, maxGap)));
    sendByte(len, c);
    if (len == 8'd0 || int'(len) > MaxLen) begin
      pushEvent(KindErr, 8'd0, 1'b0, 1'b0, ERR_LEN, c);
      return;
    end
    sum = len;
    for (int i = 0; i < int'(len); i++) begin
      idle(int'($urandom_range(0, maxGap)));
      sendByte(payload[i], c);
      pushEvent(KindPl, payload[i], i == 0, i == int'(len) - 1, 2'b00, c);
      sum = sum + payload[i];
    end
    idle(int'($urandom_range(0, maxGap)));
    sendByte(chk, c);
    if (chk == sum) pushEvent(KindOk, 8'd0, 1'b0, 1'b0, 2'b00, c);
    else            pushEvent(KindErr, 8'd0, 1'b0, 1'b0, ERR_CHK, c);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_pl_valid"}, 32'(pl_valid), 32'd0);
    checkOutput({tag, "_pl_data"}, 32'(pl_data), 32'd0);
    checkOutput({tag, "_pl_first"}, 32'(pl_first), 32'd0);
    checkOutput({tag, "_pl_last"}, 32'(pl_last), 32'd0);
    checkOutput({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    checkOutput({tag, "_err_code"}, 32'(err_code), 32'd0);
    checkOutput({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(dropModel));
  endtask

  // Monitor: whenever the DUT strobes, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (pl_valid || frame_ok || frame_err) begin
      checkOutput("strobe_count", 32'(pl_valid) + 32'(frame_ok) + 32'(frame_err), 32'd1);
      monKind = pl_valid ? KindPl : (frame_ok ? KindOk : KindErr);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event actual kind=%0d expected none at cycle %0d", monKind, cycleCount);
      end else begin
        monEvent = expQ.pop_front();
        checkOutput("event_kind", 32'(monKind), 32'(monEvent.kind));
        checkOutput("event_cycle", 32'(cycleCount), monEvent.cyc);
        if (monEvent.kind == KindPl) begin
          checkOutput("pl_data", 32'(pl_data), 32'(monEvent.data));
          checkOutput("pl_first", 32'(pl_first), 32'(monEvent.first));
          checkOutput("pl_last", 32'(pl_last), 32'(monEvent.last));
        end else if (monEvent.kind == KindErr) begin
          checkOutput("err_code", 32'(err_code), 32'(monEvent.code));
        end
      end
    end
  end

  // Directed cases, timeout handling, randomized frames and a mid-frame reset.
  initial begin
    byteQ_t     q;
    int         c;
    int         sel;
    int         nNoise;
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] chk;
    logic [7:0] b;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    reset = 1'b1;
    idle(2);

    q = '{8'h11, 8'h22, 8'h33};
    applyStimulus(8'd3, q, 8'h69, 0);
    q = '{8'h01, 8'h02};
    applyStimulus(8'd2, q, 8'h00, 1);
    q = {};
    applyStimulus(8'h00, q, 8'h00, 0);
    applyStimulus(8'h11, q, 8'h00, 0);
    q = '{8'hDE, 8'hAD};
    applyStimulus(8'd2, q, 8'h8D, 2);

    sendNoise(8'h00);
    sendNoise(8'hFF);
    sendNoise(8'h12);
    q = '{8'h7E};
    applyStimulus(8'd1, q, 8'h7F, 0);
    checkOutput("drop_cnt_noise", 32'(drop_cnt), 32'(dropModel));

    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom);
      if (b == SyncByte) b = 8'h00;
      sendNoise(b);
      if (i == 250) checkOutput("drop_cnt_near_sat", 32'(drop_cnt), 32'(dropModel));
    end
    checkOutput("drop_cnt_sat", 32'(drop_cnt), 32'(dropModel));

`ifdef UART_FRAMER_TIMEOUT_EN
    sendByte(SyncByte, c);
    sendByte(8'h04, c);
    sendByte(8'hAA, c);
    pushEvent(KindPl, 8'hAA, 1'b1, 1'b0, 2'b00, c);
    pushEvent(KindErr, 8'd0, 1'b0, 1'b0, ERR_TIMEOUT, c + TimeoutCycles - 1);
    idle(TimeoutCycles + 50);

    sendByte(SyncByte, c);
    pushEvent(KindErr, 8'd0, 1'b0, 1'b0, ERR_TIMEOUT, c + TimeoutCycles - 1);
    idle(TimeoutCycles + 20);

    sendByte(SyncByte, c);
    sendByte(8'h04, c);
    sendByte(8'hAA, c);
    pushEvent(KindPl, 8'hAA, 1'b1, 1'b0, 2'b00, c);
    idle(TimeoutCycles - 2);
    sendByte(8'h01, c);
    pushEvent(KindPl, 8'h01, 1'b0, 1'b0, 2'b00, c);
    sendByte(8'h02, c);
    pushEvent(KindPl, 8'h02, 1'b0, 1'b0, 2'b00, c);
    sendByte(8'h03, c);
    pushEvent(KindPl, 8'h03, 1'b0, 1'b1, 2'b00, c);
    sendByte(8'hB4, c);
    pushEvent(KindOk, 8'd0, 1'b0, 1'b0, 2'b00, c);
`else
    sendByte(SyncByte, c);
    sendByte(8'h04, c);
    sendByte(8'hAA, c);
    pushEvent(KindPl, 8'hAA, 1'b1, 1'b0, 2'b00, c);
    idle(3 * TimeoutCycles);
    sendByte(8'h01, c);
    pushEvent(KindPl, 8'h01, 1'b0, 1'b0, 2'b00, c);
    sendByte(8'h02, c);
    pushEvent(KindPl, 8'h02, 1'b0, 1'b0, 2'b00, c);
    sendByte(8'h03, c);
    pushEvent(KindPl, 8'h03, 1'b0, 1'b1, 2'b00, c);
    sendByte(8'hB4, c);
    pushEvent(KindOk, 8'd0, 1'b0, 1'b0, 2'b00, c);
`endif

    for (int f = 0; f < 25; f++) begin
      nNoise = int'($urandom_range(0, 3));
      for (int n = 0; n < nNoise; n++) begin
        b = 8'($urandom);
        if (b == SyncByte) b = 8'h3C;
        sendNoise(b);
      end
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      len = 8'd0;
      else if (sel == 1) len = 8'($urandom_range(MaxLen + 1, 255));
      else               len = 8'($urandom_range(1, MaxLen));
      q   = {};
      sum = len;
      if (len != 8'd0 && int'(len) <= MaxLen) begin
        for (int i = 0; i < int'(len); i++) begin
          b = ($urandom_range(0, 7) == 0) ? SyncByte : 8'($urandom);
          q.push_back(b);
          sum = sum + b;
        end
      end
      chk = ($urandom_range(0, 3) == 0) ? sum + 8'($urandom_range(1, 255)) : sum;
      applyStimulus(len, q, chk, 2);
    end
    checkOutput("drop_cnt_random", 32'(drop_cnt), 32'(dropModel));

    q = {};
    applyStimulus(8'h20, q, 8'h00, 0);
    idle(2);
    sendByte(SyncByte, c);
    sendByte(8'h05, c);
    sendByte(8'h10, c);
    pushEvent(KindPl, 8'h10, 1'b1, 1'b0, 2'b00, c);
    sendByte(8'h20, c);
    pushEvent(KindPl, 8'h20, 1'b0, 1'b0, 2'b00, c);
    reset = 1'b0;
    dropModel = 0;
    @(posedge clk);
    #1;
    checkIdleOutputs("midframe_reset");
    idle(1);
    reset = 1'b1;
    idle(3);
    q = '{8'h55};
    applyStimulus(8'd1, q, 8'h56, 0);

    idle(20);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Packet deframer directly downstream of `uart_rx`. It consumes the receiver's byte stream (`data_out`/`valid` pulses) and hunts for a sync byte. It validates a length-prefixed, checksummed frame and streams payload bytes to the application with first/last markers. Each frame ends with exactly one `frame_ok` or `frame_err` pulse, and the consumer discards the payload on error.

## Interface

Parameters:
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: largest legal payload length (1..255).
- `TIMEOUT_CYCLES`, 50000: inter-byte timeout in `clk` cycles (1 ms at 50 MHz). Must be ≥ 2.

Ports:
- `clk` in 1: 50 MHz system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset (asserted when 0).
- `in_data` in 8: received byte from `uart_rx` `data_out`.
- `in_valid` in 1: one-cycle strobe, `in_data` valid.
- `pl_data` out 8: payload byte.
- `pl_valid` out 1: one-cycle strobe for `pl_data`.
- `pl_first` out 1: qualifies `pl_valid`; first payload byte.
- `pl_last` out 1: qualifies `pl_valid`; final payload byte.
- `frame_ok` out 1: one-cycle pulse; checksum matched.
- `frame_err` out 1: one-cycle pulse; frame aborted.
- `err_code` out 2: cause, valid with `frame_err`. 01 = bad length, 10 = bad checksum, 11 = timeout.
- `drop_cnt` out 8: saturating count of non-sync bytes discarded in HUNT.

## Operation

- Frame format: `SYNC_BYTE`, `LEN`, `LEN` payload bytes, `CHK`.
- `CHK` = (LEN + Σ payload) mod 256, computed with an 8-bit wrapping accumulator.
- State **HUNT**:
  - `in_valid` with `SYNC_BYTE`: go to LEN and clear the accumulator.
  - Any other byte: `drop_cnt`+1, saturating at 255.
- State **LEN**:
  - LEN = 0 or LEN > `MAX_LEN`: `frame_err`, `err_code`=01, return to HUNT.
  - Otherwise latch the remaining count = LEN, acc = LEN, go to PAYLOAD.
- State **PAYLOAD**:
  - Each byte is emitted on `pl_*`, added to acc, and the remaining count is decremented.
  - After the last byte, go to CHK.
- State **CHK**:
  - Byte == acc: `frame_ok`; otherwise `frame_err`, `err_code`=10.
  - Return to HUNT in either case.
- A `SYNC_BYTE` value seen inside LEN/PAYLOAD/CHK is treated as data, with no resync.
- Timeout: in any state except HUNT, `TIMEOUT_CYCLES` cycles without `in_valid` give `frame_err`, `err_code`=11, return to HUNT.
- Reset mid-frame: return to HUNT with no `frame_err` emitted. Reset clears `drop_cnt`.

## Timing

- Reset values: all outputs 0, state HUNT.
- Latency: `pl_valid`, `frame_ok` and `frame_err` are registered and assert exactly 1 cycle after the causing `in_valid` cycle.
- No backpressure. Bytes arrive at most one per UART frame, so there is no overlap hazard. A strobe on every cycle must still be handled correctly.
- `pl_first` and `pl_last` both assert for LEN=1.
- `frame_ok`/`frame_err` never coincide with `pl_valid`. They are mutually exclusive and occur exactly once per frame that leaves HUNT.
- Timeout counter:
  - Reloads on every accepted `in_valid` and on entry to LEN.
  - Fires on the cycle it reaches `TIMEOUT_CYCLES`−1 with no `in_valid`.
  - If `in_valid` and expiry fall in the same cycle, the byte wins and no timeout is raised.
- `err_code` holds its value until the next `frame_err`. It is only meaningful while `frame_err`=1.

## Configuration

- `UART_FRAMER_TIMEOUT_EN` defined: timeout counter present, behaviour as above.
- Not defined:
  - Counter removed; frames wait indefinitely for bytes.
  - `err_code` 11 is never produced.
  - `TIMEOUT_CYCLES` is ignored.

## Structure

- Shared package `uart_pkg`:
  - framer state encoding (HUNT, LEN, PAYLOAD, CHK);
  - `err_code` constants `ERR_LEN`, `ERR_CHK`, `ERR_TIMEOUT`;
  - default `SYNC_BYTE`.
- One sub-module, `uart_timeout_ctr`:
  - parameterised down-counter, width $clog2(`TIMEOUT_CYCLES`);
  - inputs: `clk`, `reset`, `reload`, `enable`; output: `expired` pulse;
  - instantiated only under `UART_FRAMER_TIMEOUT_EN`.

## Test plan

- Good frame A5 03 11 22 33 69 → `pl_data` 11/22/33, `pl_first` on 11, `pl_last` on 33, then `frame_ok` 1 cycle after 69, `frame_err` never.
- Bad checksum A5 02 01 02 00 → two payload strobes, then `frame_err`, `err_code`=10.
- Bad length A5 00 and A5 11 (`MAX_LEN`=16) → `frame_err`, `err_code`=01 after the length byte; a following valid frame then succeeds.
- Noise 00 FF 12 A5 01 7E 7F → `drop_cnt`=3, `frame_ok`. Then 300 non-sync bytes → `drop_cnt` saturates at 255.
- Timeout and same-cycle race, with the macro defined and `TIMEOUT_CYCLES`=100:
  - A5 04 AA followed by silence → `frame_err` with `err_code`=11 exactly 100 cycles after AA.
  - Byte arriving on the expiry cycle → no error.
- Reset pulse during PAYLOAD → outputs 0 and no `frame_err`. The next A5 01 55 56 gives `frame_ok`.
